// File: rtl/multicycle_ctrl.sv
// ---------------------------------------------------------------------------
// multicycle_ctrl
//
// Multicycle control FSM for the ARM-style datapath built from
// Program_Counter, InstructionMemory, REGISTER_FILE and the 32-bit ALU.
// Each data-processing instruction (ADD, SUB, AND, ORR, in register or
// rotated-immediate form) walks through FETCH -> DECODE -> EXECUTE ->
// WRITEBACK.
//
// DECODE evaluates the ARM condition code against the architectural flags.
// A failed condition drops the instruction silently.
// An unsupported encoding raises a one-cycle illegal pulse and drops the
// instruction.
//
// Parameters:
//   FETCH_TIMEOUT  cycles spent waiting in FETCH for imem_ready before an
//                  illegal pulse is raised; 0 turns the watchdog off.
//
// Optional build macro:
//   MULTICYCLE_CTRL_RETIRE_CNT_EN  adds the 32-bit 'retired' output. It counts
//                                  instructions that reach WRITEBACK.
//
// Ports:
//   clk          in   1   system clock, rising edge
//   reset        in   1   asynchronous, active-high reset
//   imem_ready   in   1   instruction memory presents valid data on instr
//   instr        in   32  instruction word from InstructionMemory
//   alu_flags    in   4   ALU {N,Z,C,V}, meaningful during EXECUTE
//   pc_we        out  1   Program_Counter advance strobe
//   ir_we        out  1   instruction latch strobe
//   reg_we       out  1   REGISTER_FILE WE3
//   alu_src_imm  out  1   1: ALU operand B = ext_imm, 0: RD2
//   alu_control  out  4   ADD=0000, SUB=0001, AND=0010, ORR=0011
//   ext_imm      out  32  rotated immediate of the latched instruction
//   flags        out  4   architectural {N,Z,C,V}
//   illegal      out  1   one-cycle fault pulse
//   state_o      out  2   FETCH=00, DECODE=01, EXECUTE=10, WRITEBACK=11
//   retired      out  32  retired-instruction count (only with the macro)
// ---------------------------------------------------------------------------
module multicycle_ctrl #(
    parameter int unsigned FETCH_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        imem_ready,
    input  logic [31:0] instr,
    input  logic [3:0]  alu_flags,
    output logic        pc_we,
    output logic        ir_we,
    output logic        reg_we,
    output logic        alu_src_imm,
    output logic [3:0]  alu_control,
    output logic [31:0] ext_imm,
    output logic [3:0]  flags,
    output logic        illegal,
    output logic [1:0]  state_o
`ifdef MULTICYCLE_CTRL_RETIRE_CNT_EN
    ,
    output logic [31:0] retired
`endif
);

    typedef enum logic [1:0] {
        S_FETCH     = 2'b00,
        S_DECODE    = 2'b01,
        S_EXECUTE   = 2'b10,
        S_WRITEBACK = 2'b11
    } state_t;

    // The watchdog counter only has to reach FETCH_TIMEOUT-1: the pulse fires
    // during the last waiting cycle, so the count never has to hold
    // FETCH_TIMEOUT itself.
    localparam bit          TO_EN = (FETCH_TIMEOUT != 0);
    localparam int unsigned TW    = (FETCH_TIMEOUT > 1) ? $clog2(FETCH_TIMEOUT) : 1;
    localparam logic [TW-1:0] TO_LAST = TW'(FETCH_TIMEOUT - 1);

    state_t        state;
    logic [31:0]   ir;
    logic [TW-1:0] to_cnt;

    logic [3:0] cond_f;
    logic [1:0] op_f;
    logic       imm_f;
    logic [3:0] cmd_f;
    logic       s_f;
    logic [3:0] rd_f;
    logic [3:0] rot_f;
    logic [7:0] imm8_f;

    logic       cmd_ok;
    logic       decode_illegal;
    logic       cond_ok;
    logic       timeout_hit;
    logic       unused_rn;

    // ARM condition evaluation against {N,Z,C,V}.
    function automatic logic cond_pass(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cf, v;
        logic res;
        n   = f[3];
        z   = f[2];
        cf  = f[1];
        v   = f[0];
        res = 1'b0;
        case (c)
            4'h0:    res = z;
            4'h1:    res = !z;
            4'h2:    res = cf;
            4'h3:    res = !cf;
            4'h4:    res = n;
            4'h5:    res = !n;
            4'h6:    res = v;
            4'h7:    res = !v;
            4'h8:    res = cf & !z;
            4'h9:    res = !cf | z;
            4'hA:    res = (n == v);
            4'hB:    res = (n != v);
            4'hC:    res = !z & (n == v);
            4'hD:    res = z | (n != v);
            4'hE:    res = 1'b1;
            default: res = 1'b0;
        endcase
        return res;
    endfunction

    // Translate the ARM cmd field into the ALU's own opcode numbering.
    function automatic logic [3:0] alu_op(input logic [3:0] c);
        logic [3:0] res;
        case (c)
            4'b0100: res = 4'b0000;
            4'b0010: res = 4'b0001;
            4'b0000: res = 4'b0010;
            4'b1100: res = 4'b0011;
            default: res = 4'b0000;
        endcase
        return res;
    endfunction

    // Rotate the 8-bit immediate right by twice the 4-bit rotate field.
    // Shifting a doubled copy gives the wrap-around bits for free.
    function automatic logic [31:0] rot_imm(input logic [7:0] imm, input logic [3:0] rot);
        logic [63:0] dbl;
        dbl = {24'b0, imm, 24'b0, imm};
        dbl = dbl >> {rot, 1'b0};
        return dbl[31:0];
    endfunction

    // Field split of the latched instruction word.
    // Rn is consumed by the datapath directly and is not needed here.
    assign cond_f    = ir[31:28];
    assign op_f      = ir[27:26];
    assign imm_f     = ir[25];
    assign cmd_f     = ir[24:21];
    assign s_f       = ir[20];
    assign rd_f      = ir[15:12];
    assign rot_f     = ir[11:8];
    assign imm8_f    = ir[7:0];
    assign unused_rn = ^ir[19:16];

    // Only the four supported data-processing commands are accepted.
    always_comb begin
        cmd_ok = 1'b0;
        case (cmd_f)
            4'b0100, 4'b0010, 4'b0000, 4'b1100: cmd_ok = 1'b1;
            default:                            cmd_ok = 1'b0;
        endcase
    end

    // The NV condition, non-data-processing op classes, unknown commands
    // and writes to the PC are all treated as faults.
    // A fault is detected regardless of whether the condition would pass.
    assign decode_illegal = (cond_f == 4'hF) | (op_f != 2'b00) | !cmd_ok | (rd_f == 4'hF);
    assign cond_ok        = cond_pass(cond_f, flags);

    // The watchdog fires during the FETCH_TIMEOUT-th consecutive cycle
    // spent waiting.
    assign timeout_hit = TO_EN && (state == S_FETCH) && !imem_ready && (to_cnt == TO_LAST);

    // The fetch strobes follow the memory handshake directly, so the PC and
    // IR update on the same edge that moves the FSM into DECODE.
    // Holding reset suppresses every strobe, even if memory reports ready.
    assign pc_we   = !reset && (state == S_FETCH) && imem_ready;
    assign ir_we   = !reset && (state == S_FETCH) && imem_ready;
    assign illegal = !reset && (((state == S_DECODE) && decode_illegal) || timeout_hit);
    assign state_o = state;

    // Main sequencer. The ALU controls, immediate and register write enable
    // are registered on entry to EXECUTE and WRITEBACK. They are therefore
    // stable for the whole cycle and cleared again on the way back to FETCH.
    // Reset mid-instruction simply abandons it: no write-back, flags cleared.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= S_FETCH;
            ir          <= '0;
            flags       <= '0;
            to_cnt      <= '0;
            reg_we      <= 1'b0;
            alu_src_imm <= 1'b0;
            alu_control <= 4'b0000;
            ext_imm     <= '0;
`ifdef MULTICYCLE_CTRL_RETIRE_CNT_EN
            retired     <= '0;
`endif
        end else begin
            case (state)
                S_FETCH: begin
                    if (imem_ready) begin
                        ir     <= instr;
                        to_cnt <= '0;
                        state  <= S_DECODE;
                    end else if (timeout_hit) begin
                        to_cnt <= '0;
                    end else if (TO_EN) begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end
                S_DECODE: begin
                    if (decode_illegal || !cond_ok) begin
                        state <= S_FETCH;
                    end else begin
                        alu_control <= alu_op(cmd_f);
                        alu_src_imm <= imm_f;
                        ext_imm     <= rot_imm(imm8_f, rot_f);
                        state       <= S_EXECUTE;
                    end
                end
                S_EXECUTE: begin
                    if (s_f) begin
                        flags <= alu_flags;
                    end
                    reg_we <= 1'b1;
                    state  <= S_WRITEBACK;
                end
                S_WRITEBACK: begin
                    reg_we      <= 1'b0;
                    alu_control <= 4'b0000;
                    alu_src_imm <= 1'b0;
                    ext_imm     <= '0;
`ifdef MULTICYCLE_CTRL_RETIRE_CNT_EN
                    retired     <= retired + 32'd1;
`endif
                    state       <= S_FETCH;
                end
                default: state <= S_FETCH;
            endcase
        end
    end

endmodule
